// File: rtl/instr_mem_fetch_pkg.sv
// Shared definitions for the instruction fetch memory: default NOP
// encoding, response-source selector and address helpers.
package instr_mem_fetch_pkg;

    // addi x0, x0, 0 -- returned on faulting fetches and after reset
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Where the response word comes from: the RAM read port or the NOP constant
    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_NOP = 1'b1
    } rsp_src_e;

    // Number of word-index bits for a memory of `depth` words
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // A byte address faults when it is not word aligned or lies past the array
    function automatic logic addr_fault(input logic [63:0] addr, input int depth);
        logic [63:0] limit;
        limit = 64'(depth) << 2;
        return (addr[1:0] != 2'b00) || (addr >= limit);
    endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch-port bundle between the PC/fetch stage (master) and the
// instruction memory (slave): request handshake, response handshake, flush.
interface instr_mem_fetch_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_fault;
    logic              flush;

    modport master (
        output req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/instr_mem_fetch_imem_array.sv
// Instruction storage: DEPTH x WIDTH RAM with one synchronous write port
// and one synchronous read port. Contents are not reset; the read register
// only updates when a read is enabled, so it holds the last fetched word.
module imem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write on strobe, registered read on enable
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_idx];
        end
    end
endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with valid/ready fetch port, boot-load write port and
// address-fault detection. One registered read per accepted request; the
// response is held while the consumer stalls and can be discarded by flush.
module instr_mem_fetch
    import instr_mem_fetch_pkg::*;
#(
    parameter int              WIDTH  = 32,
    parameter int              DEPTH  = 512,
    parameter int              ADDR_W = 32,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    instr_mem_fetch_if.slave   fetch,
    input  logic               prog_en,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [WIDTH-1:0]   prog_data
);
    localparam int IDX_W = idx_width(DEPTH);

    logic             req_fault;
    logic             prog_fault;
    logic             req_ready;
    logic             accept;
    logic             rd_en;
    logic             wr_en;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] ram_rd_data;

    logic             rsp_valid_p1;
    logic             rsp_fault_p1;
    rsp_src_e         rsp_src_p1;

    assign req_fault  = addr_fault(64'(fetch.req_addr), DEPTH);
    assign prog_fault = addr_fault(64'(prog_addr), DEPTH);
    assign rd_idx     = fetch.req_addr[IDX_W+1:2];
    assign wr_idx     = prog_addr[IDX_W+1:2];

    // A new request may enter when not programming and the output slot is
    // free, being consumed, or being flushed this cycle.
    assign req_ready = !prog_en && (!rsp_valid_p1 || fetch.rsp_ready || fetch.flush);
    assign accept    = fetch.req_valid && req_ready;

    // Faulting fetches never touch the array; the NOP comes from the mux below.
    assign rd_en = accept && !req_fault;

    // Writes are gated by rst so an edge sampled during reset cannot commit.
    assign wr_en = prog_en && prog_we && !prog_fault && !rst;

    imem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (prog_data),
        .re      (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (ram_rd_data)
    );

    // Response control register: load on accept, clear on consume/flush, hold on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_p1 <= 1'b0;
            rsp_fault_p1 <= 1'b0;
            rsp_src_p1   <= SRC_NOP;
        end else if (accept) begin
            rsp_valid_p1 <= 1'b1;
            rsp_fault_p1 <= req_fault;
            rsp_src_p1   <= req_fault ? SRC_NOP : SRC_RAM;
        end else if (fetch.rsp_ready || fetch.flush) begin
            rsp_valid_p1 <= 1'b0;
        end
    end

    // ---- output stage: registered RAM word or NOP constant ----
    assign fetch.rsp_data  = (rsp_src_p1 == SRC_NOP) ? NOP : ram_rd_data;
    assign fetch.rsp_valid = rsp_valid_p1;
    assign fetch.rsp_fault = rsp_fault_p1;
    assign fetch.req_ready = req_ready;

endmodule
